instr_fetch_queue: RTL and testbench

- Fetch stage directly downstream of the pipelined program counter.
- Takes the current PC, issues byte reads to synchronous instruction memory (1-cycle read latency), and queues returned bytes tagged with their PC.
- Presents bytes to decode through a valid/ready handshake.
- Drives the PC stall input when the queue cannot accept more in-flight reads, and discards all queued and in-flight bytes on a redirect (branch/jump PC load).

---
 rtl/instr_fetch_queue_if.sv | 23 ++
 rtl/instr_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Decode-side handshake of the instruction fetch queue: head byte, its PC and valid/ready.
interface instr_fetch_queue_if #(
  parameter int AW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic [AW-1:0] out_pc;

  modport master (
    output out_valid,
    output out_byte,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_byte,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues byte reads at pc_in, queues returned bytes tagged with their PC for decode.
// Optional macro FETCH_QUEUE_STATS_EN adds flush_drop_cnt / fetch_cnt statistics outputs.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AW-1:0]            pc_in,
  input  logic                     redirect,
  output logic                     imem_en,
  output logic [AW-1:0]            imem_addr,
  input  logic [7:0]               imem_data,
  output logic                     pc_stall,
  instr_fetch_queue_if.master      dec,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]              flush_drop_cnt,
  output logic [15:0]              fetch_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [7:0]    byte_mem_q [DEPTH];
  logic [7:0]    byte_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q   [DEPTH];
  logic [AW-1:0] pc_mem_d   [DEPTH];

  logic [CW-1:0] pending;
  logic          push;
  logic          pop;

  // Outstanding reads are reserved against capacity; a same-cycle pop earns no credit.
  always_comb begin
    pending       = count_q + CW'(inflight_q);
    pc_stall      = pending >= CW'(DEPTH);
    imem_en       = !pc_stall && !redirect;
    imem_addr     = pc_in;
    dec.out_valid = (count_q != '0) && !redirect;
    dec.out_byte  = byte_mem_q[rd_ptr_q];
    dec.out_pc    = pc_mem_q[rd_ptr_q];
    push          = inflight_q && !redirect;
    pop           = dec.out_valid && dec.out_ready;
    q_count       = count_q;
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = imem_en;
    tag_d      = imem_en ? pc_in : tag_q;
    byte_mem_d = byte_mem_q;
    pc_mem_d   = pc_mem_q;
    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        byte_mem_d[wr_ptr_q] = imem_data;
        pc_mem_d[wr_ptr_q]   = tag_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        byte_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      byte_mem_q <= byte_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // The stall rule must keep every returning byte in bounds.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(DEPTH))))
    else $error("instr_fetch_queue: push into full queue");

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_drop_q, flush_drop_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [16:0] drop_sum;

  // Discarded bytes per redirect = queued entries plus the read still in flight.
  always_comb begin
    drop_sum     = 17'(flush_drop_q) + 17'(pending);
    flush_drop_d = flush_drop_q;
    if (redirect) begin
      flush_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
    fetch_cnt_d = fetch_cnt_q + 16'(imem_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_drop_q <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      flush_drop_q <= flush_drop_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign flush_drop_cnt = flush_drop_q;
  assign fetch_cnt      = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc_in;
  logic          redirect;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_data;
  logic          pc_stall;
  logic [CW-1:0] q_count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0]   flush_drop_cnt;
  logic [15:0]   fetch_cnt;
`endif

  instr_fetch_queue_if #(.AW(AW)) dec_if();

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .redirect  (redirect),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc_stall  (pc_stall),
    .dec       (dec_if),
    .q_count   (q_count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .flush_drop_cnt (flush_drop_cnt),
    .fetch_cnt      (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue contents as plain PC/byte lists plus one outstanding read.
  logic [AW-1:0] mq_pc[$];
  logic [7:0]    mq_byte[$];
  bit            m_infl;
  logic [AW-1:0] m_tag;
  int unsigned   m_drop;
  logic [15:0]   m_fetch;

  logic          s_valid, s_stall, s_en;
  logic [AW-1:0] s_pc, s_addr;
  logic [7:0]    s_byte;
  logic [CW-1:0] s_count;
  logic [15:0]   s_drop;
  logic [15:0]   d0;
  int            seen_10;

  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit redir, input logic [AW-1:0] target, input bit rdy);
    int unsigned   exp_n;
    bit            e_stall, e_en, e_valid;
    logic [AW-1:0] nxt_pc;
    logic [7:0]    nxt_data;
    redirect         = redir;
    dec_if.out_ready = rdy;
    @(negedge clk);
    s_valid = dec_if.out_valid;
    s_pc    = dec_if.out_pc;
    s_byte  = dec_if.out_byte;
    s_stall = pc_stall;
    s_en    = imem_en;
    s_addr  = imem_addr;
    s_count = q_count;
    s_drop  = 16'h0;
    exp_n   = mq_pc.size();
    e_stall = (exp_n + 32'(m_infl)) >= DEPTH;
    e_en    = !e_stall && !redir;
    e_valid = (exp_n != 0) && !redir;
    chk("pc_stall",  32'(s_stall), 32'(e_stall));
    chk("imem_en",   32'(s_en),    32'(e_en));
    chk("imem_addr", 32'(s_addr),  32'(pc_in));
    chk("q_count",   32'(s_count), exp_n);
    chk("out_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) begin
      chk("out_pc",   32'(s_pc),   32'(mq_pc[0]));
      chk("out_byte", 32'(s_byte), 32'(mq_byte[0]));
    end
    if (s_valid && s_pc == 16'h0010) seen_10++;
`ifdef FETCH_QUEUE_STATS_EN
    s_drop = flush_drop_cnt;
    chk("flush_drop_cnt", 32'(flush_drop_cnt), m_drop);
    chk("fetch_cnt",      32'(fetch_cnt),      32'(m_fetch));
    if (redir) m_drop = (m_drop + exp_n + 32'(m_infl) > 32'hFFFF) ? 32'hFFFF : m_drop + exp_n + 32'(m_infl);
    if (e_en) m_fetch = m_fetch + 16'd1;
`endif
    if (redir) begin
      mq_pc.delete();
      mq_byte.delete();
      m_infl = 1'b0;
    end else begin
      if (e_valid && rdy) begin
        void'(mq_pc.pop_front());
        void'(mq_byte.pop_front());
      end
      if (m_infl) begin
        mq_pc.push_back(m_tag);
        mq_byte.push_back(mem_f(m_tag));
      end
      m_infl = e_en;
      m_tag  = pc_in;
    end
    // Environment: synchronous memory answers a cycle later, PC holds while stalled.
    nxt_data = s_en ? mem_f(s_addr) : 8'($urandom);
    nxt_pc   = redir ? target : (s_stall ? pc_in : pc_in + 16'd1);
    @(posedge clk);
    #1;
    pc_in     = nxt_pc;
    imem_data = nxt_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(dec_if.out_valid), 32'd0);
    chk("rst q_count",   32'(q_count),          32'd0);
    chk("rst pc_stall",  32'(pc_stall),         32'd0);
    mq_pc.delete();
    mq_byte.delete();
    m_infl           = 1'b0;
    m_tag            = '0;
    m_drop           = 0;
    m_fetch          = '0;
    pc_in            = '0;
    redirect         = 1'b0;
    dec_if.out_ready = 1'b0;
    imem_data        = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    pc_in            = '0;
    redirect         = 1'b0;
    imem_data        = '0;
    dec_if.out_ready = 1'b0;
    seen_10          = 0;
    d0               = '0;

    // Free run from reset: first byte at cycle 2.
    do_reset();
    cyc(1'b0, '0, 1'b1);
    chk("A c0 imem_en", 32'(s_en), 32'd1);
    chk("A c0 addr",    32'(s_addr), 32'h0);
    cyc(1'b0, '0, 1'b1);
    chk("A c1 valid",   32'(s_valid), 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("A c2 valid",   32'(s_valid), 32'd1);
    chk("A c2 pc",      32'(s_pc),    32'h0);
    chk("A c2 byte",    32'(s_byte),  32'h0);
    repeat (20) cyc(1'b0, '0, 1'b1);

    // Backpressure: exactly DEPTH bytes held, then drained in order.
    do_reset();
    repeat (8) cyc(1'b0, '0, 1'b0);
    chk("B q_count",  32'(s_count), 32'd4);
    chk("B pc_stall", 32'(s_stall), 32'd1);
    chk("B head pc",  32'(s_pc),    32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("B drain valid", 32'(s_valid), 32'd1);
      chk("B drain pc",    32'(s_pc),    32'(i));
    end
    repeat (6) cyc(1'b0, '0, 1'b1);

    // Redirect with a full queue.
    repeat (8) cyc(1'b0, '0, 1'b0);
    chk("C full", 32'(s_count), 32'd4);
    d0 = s_drop;
    cyc(1'b1, 16'h1234, 1'b1);
    chk("C redir valid", 32'(s_valid), 32'd0);
    chk("C redir en",    32'(s_en),    32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("C R+1 count", 32'(s_count), 32'd0);
    chk("C R+1 en",    32'(s_en),    32'd1);
    chk("C R+1 addr",  32'(s_addr),  32'h1234);
`ifdef FETCH_QUEUE_STATS_EN
    chk("C drop delta", 32'(s_drop - d0), 32'd4);
`endif
    cyc(1'b0, '0, 1'b1);
    chk("C R+2 valid", 32'(s_valid), 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("C R+3 valid", 32'(s_valid), 32'd1);
    chk("C R+3 pc",    32'(s_pc),    32'h1234);
    chk("C R+3 byte",  32'(s_byte),  32'h26);

    // Redirect while the read of 0x0010 is in flight.
    seen_10 = 0;
    cyc(1'b1, 16'h0010, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("D en",   32'(s_en),   32'd1);
    chk("D addr", 32'(s_addr), 32'h0010);
    cyc(1'b1, 16'h0040, 1'b1);
    repeat (10) cyc(1'b0, '0, 1'b1);
    chk("D 0x10 never seen", 32'(seen_10), 32'd0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    cyc(1'b1, 16'h0100, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("E q_count", 32'(s_count), 32'd2);
    end

    // Random traffic with redirects, backpressure and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(($urandom_range(0, 9) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
